// File: rtl/picorv32_wb_master.sv
// picorv32 native memory port to single-beat pipelined Wishbone B4 initiator.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module picorv32_wb_master #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [3:0]  i_mem_wstrb,
  output logic        o_mem_ready,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nx;
  logic        we_q, we_nx;
  logic [31:0] addr_q, addr_nx;
  logic [31:0] data_q, data_nx;
  logic [3:0]  sel_q, sel_nx;
  logic [31:0] rdata_q, rdata_nx;
  logic        err_q, err_nx;
  logic        timeout;

`ifdef WB_MASTER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Counter restarts every time we sit in IDLE, so it counts only bus-cycle time.
  always_ff @(posedge i_clk) begin
    if (i_reset || state == IDLE) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state == REQ || state == WAIT) &&
                   (tmo_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [TIMEOUT_W-1:0] unused_tmo_cfg;
  assign unused_tmo_cfg = TIMEOUT_W'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      we_q    <= we_nx;
      addr_q  <= addr_nx;
      data_q  <= data_nx;
      sel_q   <= sel_nx;
      rdata_q <= rdata_nx;
      err_q   <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    we_nx    = we_q;
    addr_nx  = addr_q;
    data_nx  = data_q;
    sel_nx   = sel_q;
    rdata_nx = rdata_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (i_mem_valid) begin
          state_nx = REQ;
          addr_nx  = i_mem_addr;
          data_nx  = i_mem_wdata;
          we_nx    = |i_mem_wstrb;
          sel_nx   = (|i_mem_wstrb) ? i_mem_wstrb : 4'hF;
        end
      end
      REQ, WAIT: begin
        // A responder answer always beats the watchdog, and err beats ack.
        if (i_wb_err) begin
          state_nx = DONE;
          rdata_nx = '0;
          err_nx   = 1'b1;
        end else if (i_wb_ack) begin
          state_nx = DONE;
          err_nx   = 1'b0;
          if (!we_q) rdata_nx = i_wb_data;
        end else if (timeout) begin
          state_nx = DONE;
          rdata_nx = '0;
          err_nx   = 1'b1;
        end else if (state == REQ && !i_wb_stall) begin
          state_nx = WAIT;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign o_wb_cyc    = (state == REQ) || (state == WAIT);
  assign o_wb_stb    = (state == REQ);
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = data_q;
  assign o_wb_sel    = sel_q;
  assign o_mem_ready = (state == DONE);
  assign o_mem_err   = (state == DONE) && err_q;
  assign o_mem_rdata = rdata_q;
  assign o_busy      = (state != IDLE);

endmodule
